pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 8'h00: PC value loaded on reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge only).
REQ-004 stall  input  1  hold current PC; no state advance except reset and halt.
REQ-005 halt  input  1  request permanent stop until reset.
REQ-006 jump_en  input  1  absolute redirect request.
REQ-007 jump_addr  input  8  absolute jump target.
REQ-008 branch_en  input  1  conditional relative branch request.
REQ-009 zero_flag  input  1  branch condition; branch taken when branch_en=1 and zero_flag=1.
REQ-010 branch_offset  input  5  two's-complement offset, range -16..+15, taken from instruction bits [4:0].
REQ-011 PCinst  output  8  registered PC presented to instruction memory.
REQ-012 valid  output  1  registered; 1 = PCinst addresses an instruction to be executed.
REQ-013 flush  output  1  registered; 1 for exactly one cycle after any taken redirect.
REQ-014 halted  output  1  registered; 1 while in HALTED state.

Function
REQ-015 FSM states: BOOT, RUN, HALTED; state encoding is internal.
REQ-016 BOOT: entered on reset; lasts one cycle; valid=0; next state RUN with PCinst unchanged (RESET_VECTOR), unless halt=1, which goes to HALTED.
REQ-017 RUN: valid=1; per cycle, PCinst update priority is halt > stall > jump > branch taken > increment.
REQ-018 halt=1 in RUN: next state HALTED; PCinst frozen; valid->0; halted->1; flush->0.
REQ-019 stall=1 in RUN (halt=0): PCinst, valid, and state held; flush->0; jump/branch requests in the same cycle are ignored, not queued.
REQ-020 jump_en=1 (no halt/stall): PCinst <= jump_addr; flush<=1 next cycle.
REQ-021 Branch taken, jump_en=0: PCinst <= PCinst + 1 + sign_extend(branch_offset), computed modulo 256; flush<=1 next cycle.
REQ-022 branch_en=1 with zero_flag=0 is not taken: behaves as increment; flush<=0.
REQ-023 Increment: PCinst <= PCinst + 1 modulo 256; 8'hFF wraps to 8'h00 with no error indication.
REQ-024 Simultaneous jump_en and branch taken: jump wins; only one flush pulse.
REQ-025 Branch arithmetic wraps both directions: e.g., 8'h02 with offset -16 gives 8'hF3; 8'hF8 with offset +15 gives 8'h08.
REQ-026 flush is never high for two consecutive cycles unless a redirect is also taken in the cycle the first pulse is high.
REQ-027 HALTED: absorbing; all inputs except reset ignored; PCinst frozen; valid=0; flush=0; halted=1.
REQ-028 Redirect latency: target appears on PCinst the cycle after the request edge; no bubbles are inserted by this block.

Reset
REQ-029 reset=0 at a rising edge, in any state including mid-stall, mid-redirect, or HALTED: PCinst<=RESET_VECTOR, valid<=0, flush<=0, halted<=0, state<=BOOT.
REQ-030 reset overrides all other inputs in the same cycle; outputs are undefined only before the first reset edge.

Verification
REQ-031 Reset, then 4 free cycles -> PCinst 00,00,01,02,03; valid 0,1,1,1,1; flush stays 0.
REQ-032 PC at 8'hFE, no requests -> FF then 00; valid stays 1.
REQ-033 PC=8'h10, branch_en=1, zero_flag=1, offset=5'b10000 -> PCinst=8'h01, flush=1 for one cycle; repeat with zero_flag=0 -> 8'h11, flush=0.
REQ-034 PC=8'h20, jump_en=1 jump_addr=8'h80, branch taken offset=+3, same cycle -> PCinst=8'h80, single flush pulse; with stall=1 also asserted -> PCinst stays 8'h20, flush=0.
REQ-035 halt=1 at PC=8'h05 -> halted=1, valid=0, PCinst=8'h05 frozen across 10 cycles of random jump/branch/stall; then reset=0 -> PCinst=RESET_VECTOR, halted=0, BOOT.
REQ-036 reset=0 asserted during a stall and during a flush cycle -> outputs return to reset values on that edge.

Source files
------------

// File: rtl/pc_fetch.sv
// Program-counter fetch stage: produces the instruction address each cycle,
// applying halt, stall, absolute jumps and zero-conditional relative branches.
module pc_fetch #(
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic       halt,
    input  logic       jump_en,
    input  logic [7:0] jump_addr,
    input  logic       branch_en,
    input  logic       zero_flag,
    input  logic [4:0] branch_offset,
    output logic [7:0] PCinst,
    output logic       valid,
    output logic       flush,
    output logic       halted
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       valid_q, valid_d;
    logic       flush_q, flush_d;
    logic       halted_q, halted_d;

    logic [7:0] offset_ext;
    logic [7:0] branch_target;
    logic       branch_taken;

    // Relative target is measured from the next sequential address; 8-bit add wraps.
    assign offset_ext    = {{3{branch_offset[4]}}, branch_offset};
    assign branch_target = pc_q + 8'd1 + offset_ext;
    assign branch_taken  = branch_en && zero_flag;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = halt ? HALTED : RUN;
            RUN:     if (halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        valid_d  = 1'b0;
        flush_d  = 1'b0;
        halted_d = 1'b0;
        case (state_q)
            BOOT: begin
                valid_d  = !halt;
                halted_d = halt;
            end
            RUN: begin
                if (halt) begin
                    halted_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    // Stalled redirects are dropped, not remembered.
                    if (!stall) begin
                        if (jump_en) begin
                            pc_d    = jump_addr;
                            flush_d = 1'b1;
                        end else if (branch_taken) begin
                            pc_d    = branch_target;
                            flush_d = 1'b1;
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                end
            end
            HALTED: halted_d = 1'b1;
            default: ;
        endcase
    end

    assign PCinst = pc_q;
    assign valid  = valid_q;
    assign flush  = flush_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus pushes model predictions into a
// queue; a monitor on the falling edge pops and compares against the DUT.
module tb_pc_fetch;

    localparam logic [7:0] RV = 8'h00;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       halt = 1'b0;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic       branch_en = 1'b0;
    logic       zero_flag = 1'b0;
    logic [4:0] branch_offset = 5'd0;
    logic [7:0] PCinst;
    logic       valid, flush, halted;

    pc_fetch #(.RESET_VECTOR(RV)) dut (
        .clock(clock), .reset(reset), .stall(stall), .halt(halt),
        .jump_en(jump_en), .jump_addr(jump_addr), .branch_en(branch_en),
        .zero_flag(zero_flag), .branch_offset(branch_offset),
        .PCinst(PCinst), .valid(valid), .flush(flush), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pc;
        bit valid;
        bit flush;
        bit halted;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: plain behavioural description of the fetch rules.
    bit m_booting = 1'b0;
    bit m_stopped = 1'b0;
    int m_pc = 0;
    bit m_valid = 1'b0;
    bit m_flush = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % 256) + 256) % 256;
    endfunction

    task automatic model(input bit r, input bit s, input bit h, input bit je,
                         input int ja, input bit be, input bit zf, input int off5);
        int rel;
        rel = (off5 >= 16) ? off5 - 32 : off5;
        if (!r) begin
            m_booting = 1; m_stopped = 0; m_pc = RV; m_valid = 0; m_flush = 0;
        end else if (m_stopped) begin
            m_valid = 0; m_flush = 0;
        end else if (m_booting) begin
            m_booting = 0; m_flush = 0;
            m_stopped = h; m_valid = !h;
        end else if (h) begin
            m_stopped = 1; m_valid = 0; m_flush = 0;
        end else if (s) begin
            m_flush = 0;
        end else if (je) begin
            m_pc = ja; m_flush = 1;
        end else if (be && zf) begin
            m_pc = wrap(m_pc + 1 + rel); m_flush = 1;
        end else begin
            m_pc = wrap(m_pc + 1); m_flush = 0;
        end
    endtask

    // One clock of stimulus: drive, let the edge happen, then predict.
    task automatic step(input string tag, input bit r, input bit s, input bit h,
                        input bit je, input logic [7:0] ja, input bit be,
                        input bit zf, input logic [4:0] off);
        exp_t e;
        reset = r; stall = s; halt = h; jump_en = je; jump_addr = ja;
        branch_en = be; zero_flag = zf; branch_offset = off;
        @(posedge clock);
        #1;
        model(r, s, h, je, int'(ja), be, zf, int'(off));
        e.pc = m_pc; e.valid = m_valid; e.flush = m_flush;
        e.halted = m_stopped; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 8'h00, 0, 0, 5'd0);
    endtask

    task automatic jump_to(input string tag, input logic [7:0] a);
        step(tag, 1, 0, 0, 1, a, 0, 0, 5'd0);
    endtask

    // Monitor: every falling edge the DUT presents one set of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".pc"},     int'(PCinst), e.pc);
                check({e.tag, ".valid"},  int'(valid),  int'(e.valid));
                check({e.tag, ".flush"},  int'(flush),  int'(e.flush));
                check({e.tag, ".halted"}, int'(halted), int'(e.halted));
            end
        end
    end

    initial begin
        bit r, s, h, je, be, zf;
        // Free run from reset: 00,00,01,02,03.
        step("reset", 0, 0, 0, 0, 8'h00, 0, 0, 5'd0);
        idle("free", 4);

        // Wrap at the top of the address space.
        jump_to("jmp_fe", 8'hFE);
        idle("wrap", 2);

        // Backward branch of -16 from 0x10, then not-taken branch.
        jump_to("jmp_10", 8'h10);
        step("br_neg16", 1, 0, 0, 0, 8'h00, 1, 1, 5'b10000);
        idle("after_br", 1);
        jump_to("jmp_10b", 8'h10);
        step("br_nt", 1, 0, 0, 0, 8'h00, 1, 0, 5'b10000);

        // Branch wrap in both directions.
        jump_to("jmp_02", 8'h02);
        step("br_wrap_dn", 1, 0, 0, 0, 8'h00, 1, 1, 5'b10000);
        jump_to("jmp_f8", 8'hF8);
        step("br_wrap_up", 1, 0, 0, 0, 8'h00, 1, 1, 5'b01111);

        // Jump beats branch; stall beats both.
        jump_to("jmp_20", 8'h20);
        step("jmp_br", 1, 0, 0, 1, 8'h80, 1, 1, 5'd3);
        idle("after_jb", 1);
        jump_to("jmp_20b", 8'h20);
        step("stall_jb", 1, 1, 0, 1, 8'h80, 1, 1, 5'd3);
        step("stall_jb2", 1, 1, 0, 1, 8'h80, 1, 1, 5'd3);
        idle("unstall", 1);

        // Halt at 0x05, hammer with requests, then reset out of it.
        jump_to("jmp_05", 8'h05);
        step("halt", 1, 0, 1, 0, 8'h00, 0, 0, 5'd0);
        for (int i = 0; i < 10; i++)
            step("halted_rand", 1, 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
        step("reset_halt", 0, 0, 0, 0, 8'h00, 0, 0, 5'd0);
        idle("reboot", 3);

        // Reset during a stall and during a flush cycle.
        step("stall", 1, 1, 0, 0, 8'h00, 0, 0, 5'd0);
        step("reset_stall", 0, 1, 0, 1, 8'h44, 0, 0, 5'd0);
        idle("reboot2", 2);
        jump_to("jmp_33", 8'h33);
        step("reset_flush", 0, 0, 0, 1, 8'h55, 1, 1, 5'd2);
        idle("reboot3", 2);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) >= 2);
            h  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 20);
            je = ($urandom_range(0, 99) < 15);
            be = ($urandom_range(0, 99) < 35);
            zf = 1'($urandom);
            step("rand", r, s, h, je, 8'($urandom), be, zf, 5'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        check("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
